// File: rtl/acb_mem_responder.sv
// ACB memory responder: byte-masked write / full-word read on a 64-bit array; ACB_MEM_RESPONDER_RANGE_CHECK_EN adds window checking.
// Latency: request accepted at E0, response valid from E1; one request in flight.
// Backpressure: response held stable in RESP until read_req; write_ack low outside IDLE.
module acb_mem_responder #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [35:0] BASE_ADDR  = 36'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [109:0] ACB_MEM_REQUEST_pipe_write_data,
    input  logic         ACB_MEM_REQUEST_pipe_write_req,
    output logic         ACB_MEM_REQUEST_pipe_write_ack,
    output logic [64:0]  ACB_MEM_RESPONSE_pipe_read_data,
    input  logic         ACB_MEM_RESPONSE_pipe_read_req,
    output logic         ACB_MEM_RESPONSE_pipe_read_ack
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    rd_q, rd_d;
    logic [7:0]              mask_q, mask_d;
    logic [35:0]             addr_q, addr_d;
    logic [63:0]             wdata_q, wdata_d;
    logic [64:0]             resp_q, resp_d;
    logic [63:0]             mem_q [DEPTH];

    logic [35:0]             offset;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    err;
    logic                    mem_we;
    logic                    unused_bits;

    assign offset = addr_q - BASE_ADDR;
    assign idx    = offset[ADDR_WIDTH+2:3];

`ifdef ACB_MEM_RESPONDER_RANGE_CHECK_EN
    assign err = (addr_q < BASE_ADDR) || ((offset >> (ADDR_WIDTH + 3)) != 36'd0);
`else
    // Out-of-window addresses alias into the array through the truncated index.
    assign err = 1'b0;
`endif

    // Lock bit is reserved; low address bits never select within a word.
    assign unused_bits = ^{ACB_MEM_REQUEST_pipe_write_data[109], offset};

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ACB_MEM_REQUEST_pipe_write_req) begin
                    rd_d    = ACB_MEM_REQUEST_pipe_write_data[108];
                    mask_d  = ACB_MEM_REQUEST_pipe_write_data[107:100];
                    addr_d  = ACB_MEM_REQUEST_pipe_write_data[99:64];
                    wdata_d = ACB_MEM_REQUEST_pipe_write_data[63:0];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (rd_q) begin
                    resp_d = err ? {1'b1, 64'd0} : {1'b0, mem_q[idx]};
                end else begin
                    resp_d = {err, 64'd0};
                    mem_we = ~err;
                end
                state_d = RESP;
            end
            RESP: begin
                if (ACB_MEM_RESPONSE_pipe_read_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            mask_q  <= 8'd0;
            addr_q  <= 36'd0;
            wdata_q <= 64'd0;
            resp_q  <= 65'd0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
        end
    end

    // Array is not reset; a write is only committed from ACCESS, which reset clears.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ACB_MEM_REQUEST_pipe_write_ack  = reset && (state_q == IDLE);
    assign ACB_MEM_RESPONSE_pipe_read_ack  = (state_q == RESP);
    assign ACB_MEM_RESPONSE_pipe_read_data = resp_q;

endmodule

// File: tb/tb_acb_mem_responder.sv
// Directed bench for acb_mem_responder with hand-computed expectations; BASE_ADDR is nonzero.
module tb_acb_mem_responder;

    localparam logic [35:0] BASE = 36'h1000;

    logic         clk = 1'b0;
    logic         reset;
    logic [109:0] wdat;
    logic         wreq;
    logic         wack;
    logic [64:0]  rdata;
    logic         rreq;
    logic         rack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    acb_mem_responder #(.ADDR_WIDTH(8), .BASE_ADDR(BASE)) dut (
        .clk                             (clk),
        .reset                           (reset),
        .ACB_MEM_REQUEST_pipe_write_data (wdat),
        .ACB_MEM_REQUEST_pipe_write_req  (wreq),
        .ACB_MEM_REQUEST_pipe_write_ack  (wack),
        .ACB_MEM_RESPONSE_pipe_read_data (rdata),
        .ACB_MEM_RESPONSE_pipe_read_req  (rreq),
        .ACB_MEM_RESPONSE_pipe_read_ack  (rack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_req(input logic rd, input logic [7:0] m, input logic [35:0] a,
                             input logic [63:0] d, output int acc);
        int n;
        n    = 0;
        wreq = 1'b1;
        wdat = {1'b0, rd, m, a, d};
        while (wack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", {64'd0, wack}, 65'd1);
        acc = cyc;
        @(negedge clk);
        wreq = 1'b0;
    endtask

    task automatic wait_resp(input int acc, output logic [64:0] resp, output int lat);
        int n;
        n = 0;
        while (rack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_vld", {64'd0, rack}, 65'd1);
        lat  = cyc - acc;
        resp = rdata;
    endtask

    task automatic txn(input logic rd, input logic [7:0] m, input logic [35:0] a,
                       input logic [63:0] d, output logic [64:0] resp, output int acc, output int lat);
        start_req(rd, m, a, d, acc);
        wait_resp(acc, resp, lat);
        if (rreq) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [64:0] r;
    int          acc, lat;
    int          accs [8];
    logic [63:0] bb_dat [4];
    logic [64:0] exp_v;

    initial begin
        bb_dat[0] = 64'h0000_0000_0000_0001;
        bb_dat[1] = 64'h8000_0000_0000_0000;
        bb_dat[2] = 64'hCAFE_BABE_0BAD_F00D;
        bb_dat[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        reset = 1'b0;
        wreq  = 1'b0;
        rreq  = 1'b0;
        wdat  = '0;

        repeat (3) @(negedge clk);
        check("rst_wack",  {64'd0, wack}, 65'd0);
        check("rst_rack",  {64'd0, rack}, 65'd0);
        check("rst_rdata", rdata, 65'd0);
        reset = 1'b1;
        #1 check("post_rst_wack", {64'd0, wack}, 65'd1);
        @(negedge clk);

        rreq = 1'b1;
        txn(1'b0, 8'hFF, BASE + 36'h10, 64'h1122334455667788, r, acc, lat);
        check("wr_resp", r, 65'd0);
        check("wr_lat", 65'(lat), 65'd2);
        txn(1'b1, 8'h00, BASE + 36'h10, 64'd0, r, acc, lat);
        check("rd_resp", r, {1'b0, 64'h1122334455667788});
        check("rd_lat", 65'(lat), 65'd2);

        txn(1'b0, 8'h0F, BASE + 36'h10, 64'hAAAAAAAAAAAAAAAA, r, acc, lat);
        txn(1'b1, 8'h00, BASE + 36'h13, 64'd0, r, acc, lat);
        check("mask0F_rd", r, {1'b0, 64'h11223344AAAAAAAA});

        txn(1'b0, 8'h00, BASE + 36'h10, 64'hFFFFFFFFFFFFFFFF, r, acc, lat);
        check("mask00_wr_resp", r, 65'd0);
        txn(1'b1, 8'hFF, BASE + 36'h10, 64'd0, r, acc, lat);
        check("mask00_rd", r, {1'b0, 64'h11223344AAAAAAAA});

        // Backpressure: hold read_req low while a competing write is offered.
        rreq = 1'b0;
        start_req(1'b1, 8'h00, BASE + 36'h10, 64'd0, acc);
        wait_resp(acc, r, lat);
        wreq = 1'b1;
        wdat = {1'b0, 1'b0, 8'hFF, BASE + 36'h10, 64'hDEADDEADDEADDEAD};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_rack", {64'd0, rack}, 65'd1);
            check("bp_data", rdata, {1'b0, 64'h11223344AAAAAAAA});
            check("bp_wack", {64'd0, wack}, 65'd0);
        end
        wreq = 1'b0;
        rreq = 1'b1;
        @(negedge clk);
        check("bp_released", {64'd0, rack}, 65'd0);
        txn(1'b1, 8'h00, BASE + 36'h10, 64'd0, r, acc, lat);
        check("bp_no_write", r, {1'b0, 64'h11223344AAAAAAAA});

        // Window boundaries.
        txn(1'b0, 8'hFF, BASE, 64'h0123456789ABCDEF, r, acc, lat);
        txn(1'b0, 8'hFF, BASE + 36'h7F8, 64'hFEDCBA9876543210, r, acc, lat);
        check("top_word_wr", r, 65'd0);
        txn(1'b1, 8'h00, BASE + 36'h800, 64'd0, r, acc, lat);
`ifdef ACB_MEM_RESPONDER_RANGE_CHECK_EN
        check("oor_hi_rd", r, {1'b1, 64'd0});
`else
        check("oor_hi_rd", r, {1'b0, 64'h0123456789ABCDEF});
`endif
        txn(1'b1, 8'h00, BASE - 36'h8, 64'd0, r, acc, lat);
`ifdef ACB_MEM_RESPONDER_RANGE_CHECK_EN
        check("oor_lo_rd", r, {1'b1, 64'd0});
`else
        check("oor_lo_rd", r, {1'b0, 64'hFEDCBA9876543210});
`endif
        txn(1'b0, 8'hFF, BASE + 36'h800, 64'h5555555555555555, r, acc, lat);
`ifdef ACB_MEM_RESPONDER_RANGE_CHECK_EN
        check("oor_wr_resp", r, {1'b1, 64'd0});
        exp_v = {1'b0, 64'h0123456789ABCDEF};
`else
        check("oor_wr_resp", r, 65'd0);
        exp_v = {1'b0, 64'h5555555555555555};
`endif
        txn(1'b1, 8'h00, BASE, 64'd0, r, acc, lat);
        check("word0_after_oor", r, exp_v);

        // Reset while a response is pending.
        rreq = 1'b0;
        start_req(1'b1, 8'h00, BASE + 36'h10, 64'd0, acc);
        wait_resp(acc, r, lat);
        #2 reset = 1'b0;
        #1;
        check("rst_resp_rack",  {64'd0, rack}, 65'd0);
        check("rst_resp_wack",  {64'd0, wack}, 65'd0);
        check("rst_resp_rdata", rdata, 65'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_rel_wack", {64'd0, wack}, 65'd1);
        rreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_rack", {64'd0, rack}, 65'd0);
        end

        // Reset during ACCESS: the latched write must not land.
        start_req(1'b0, 8'hFF, BASE + 36'h10, 64'h0F0F0F0F0F0F0F0F, acc);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn(1'b1, 8'h00, BASE + 36'h10, 64'd0, r, acc, lat);
        check("rst_access_rd", r, {1'b0, 64'h11223344AAAAAAAA});

        // Back-to-back with read_req held high.
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 8'hFF, BASE + 36'h100 + 36'(8 * i), bb_dat[i], r, accs[i], lat);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 8'h00, BASE + 36'h100 + 36'(8 * i), 64'd0, r, accs[4+i], lat);
            check("bb_rd", r, {1'b0, bb_dat[i]});
        end
        for (int i = 1; i < 8; i++) begin
            check("bb_spacing", 65'(accs[i] - accs[i-1]), 65'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acb_mem_responder.md
# acb_mem_responder

Memory-side responder for the ACB accelerator memory pipes. It accepts 110-bit request words, performs a byte-masked write or a full-word read on an internal 64-bit-wide memory array, and returns a 65-bit response word. It sits opposite the accelerator's ACB initiator and serves as the memory model and on-chip scratch store for accelerator jobs.

## Interface
- ADDR_WIDTH, 8: log2 of array depth in 64-bit words (default 256 words).
- BASE_ADDR, 36'h0: byte address of word 0; must be aligned to 8 bytes.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ACB_MEM_REQUEST_pipe_write_data  in  110  request word: [109] lock (reserved, ignored); [108] rd (1 read, 0 write); [107:100] byte mask; [99:64] byte address; [63:0] write data.
- ACB_MEM_REQUEST_pipe_write_req  in  1  request valid.
- ACB_MEM_REQUEST_pipe_write_ack  out  1  responder ready; request transfers on a cycle with req & ack.
- ACB_MEM_RESPONSE_pipe_read_data  out  65  response word: [64] error; [63:0] read data (0 for writes).
- ACB_MEM_RESPONSE_pipe_read_req  in  1  consumer ready.
- ACB_MEM_RESPONSE_pipe_read_ack  out  1  response valid; response transfers on a cycle with req & ack.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: write_ack = 1. On write_req & write_ack, latch the request into registers and go to ACCESS.
- ACCESS: compute word index = (addr - BASE_ADDR) >> 3. Address bits [2:0] are ignored.
  - Write: for each mask bit i set, array byte i ← data byte i; response = {1'b0, 64'd0}.
  - Read: response = {1'b0, array[index]}; the mask is ignored.
  - Mask 8'h00 on a write: no array change; normal response.
  - Go to RESP.
- RESP: read_ack = 1, with the response data held stable. On read_req & read_ack, go to IDLE. Otherwise stay in RESP indefinitely; backpressure never drops or alters the response.
- Only one request is in flight at a time. write_ack = 0 in ACCESS and RESP.
- Reset values:
  - write_ack = 0 while reset is low, and 1 on the first cycle after deassertion.
  - read_ack = 0.
  - read_data = 65'd0.
  - Latched request registers = 0.
  - Array contents are not reset.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and any pending response is discarded. A write that was latched but has not reached the ACCESS edge is not performed.

## Timing
- Request accepted at edge E0. ACCESS occupies cycle E0→E1, and the array write or read is registered at E1. read_ack = 1 from E1.
- Minimum request-to-response latency: 2 cycles.
- Minimum spacing between accepted requests: 3 cycles (IDLE, ACCESS, RESP with read_req already high).
- read_req high before read_ack is legal; the transfer completes at the first edge where both are 1.
- write_req is ignored outside IDLE. The requester holds its data until it sees ack.
- A read issued after a write to the same address returns the new data; no forwarding hazard exists because requests are serialised.

## Configuration
- ACB_MEM_RESPONDER_RANGE_CHECK_EN defined:
  - An address below BASE_ADDR, or at/above BASE_ADDR + 8·2^ADDR_WIDTH, returns error = 1 and data = 0.
  - Writes to such an address do not modify the array.
- Undefined:
  - No error is ever flagged (bit 64 is always 0).
  - The word index wraps modulo 2^ADDR_WIDTH, so out-of-window addresses alias into the array.

## Test plan
- Write 64'h1122334455667788, mask 8'hFF, addr BASE+0x10, then read the same address: response 0 then {0, 64'h1122334455667788}; read_ack first high 2 cycles after each acceptance.
- Write 64'hAAAAAAAAAAAAAAAA with mask 8'h0F to that word, then read: {0, 64'h11223344AAAAAAAA}.
- Hold read_req = 0 for 10 cycles after a read: read_ack stays 1 and data is stable; write_ack stays 0; a new write_req is not accepted until the response transfers.
- With the macro defined, read BASE + 8·256: {1, 64'd0}; a write there leaves word 0 unchanged. Without it, the same write lands in word 0.
- Pull reset low while in RESP: read_ack drops to 0 asynchronously. After release, write_ack = 1 and no stale response appears.
- Back-to-back: 4 writes followed by 4 reads with read_req held high: each accepted request is spaced exactly 3 cycles apart, and the read data matches the written data.
